// File: rtl/pcie_tl_pkg.sv
// Shared transmission-layer definitions: default FIFO widths and the
// one-hot control FSM state encodings used by both FIFOs and the FSM.
package pcie_tl_pkg;
    localparam int DATA_W = 6;
    localparam int ADDR_W = 2;
    localparam int U_W    = 4;

    typedef enum logic [4:0] {
        RESET  = 5'b00001,
        INIT   = 5'b00010,
        IDLE   = 5'b00100,
        ACTIVE = 5'b01000,
        ERROR  = 5'b10000
    } tl_state_t;
endpackage

// File: rtl/fifo_umbral_if.sv
// Handshake/status bundle between a FIFO user (master) and fifo_umbral (slave).
import pcie_tl_pkg::*;

interface fifo_umbral_if #(
    parameter int DATA_W = pcie_tl_pkg::DATA_W,
    parameter int ADDR_W = pcie_tl_pkg::ADDR_W,
    parameter int U_W    = pcie_tl_pkg::U_W
) ();
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_in;
    logic [U_W-1:0]    umbral_alto;
    logic [U_W-1:0]    umbral_bajo;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              error;

    modport master (
        output push, pop, data_in, umbral_alto, umbral_bajo,
        input  data_out, valid_out, count, full, empty,
               almost_full, almost_empty, error
    );

    modport slave (
        input  push, pop, data_in, umbral_alto, umbral_bajo,
        output data_out, valid_out, count, full, empty,
               almost_full, almost_empty, error
    );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array with synchronous write and registered read.
// Only the read register is reset so data_out comes up as zero.
import pcie_tl_pkg::*;

module fifo_mem #(
    parameter int DATA_W = pcie_tl_pkg::DATA_W,
    parameter int ADDR_W = pcie_tl_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: a same-edge write to rd_addr returns the old word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/fifo_umbral.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds and
// overflow/underflow error; define FIFO_STICKY_ERROR_EN for a latching error.
import pcie_tl_pkg::*;

module fifo_umbral #(
    parameter int DATA_W = pcie_tl_pkg::DATA_W,
    parameter int ADDR_W = pcie_tl_pkg::ADDR_W,
    parameter int U_W    = pcie_tl_pkg::U_W
) (
    input  logic          clk,
    input  logic          reset,
    fifo_umbral_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              valid_q;
    logic              error_q;
    logic              full;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;
    logic              offence;

    assign full    = (count_q == DEPTH);
    assign empty   = (count_q == '0);
    // A full FIFO still takes a push when a pop frees a slot on the same edge.
    assign push_ok = bus.push && (!full || bus.pop);
    assign pop_ok  = bus.pop && !empty;
    assign offence = (bus.push && full && !bus.pop) || (bus.pop && empty);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            valid_q <= pop_ok;
`ifdef FIFO_STICKY_ERROR_EN
            error_q <= error_q | offence;
`else
            error_q <= offence;
`endif
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok && reset),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (bus.data_out)
    );

    assign bus.valid_out    = valid_q;
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (U_W'(count_q) >= bus.umbral_alto);
    assign bus.almost_empty = (U_W'(count_q) <= bus.umbral_bajo);
    assign bus.error        = error_q;
endmodule
